// File: rtl/fx3_in_path_reader.sv
// fx3_in_path_reader: drains one FX3 DMA buffer from the synchronous
// slave-FIFO bus into a ping-pong FIFO, one PPFIFO side at a time.
// Reads are issued while a side has room. In-flight reads are tracked by a
// READ_LATENCY-deep valid shift register, so each returning word is written
// exactly once and the side is released only after its reads have drained.
module fx3_in_path_reader #(
  parameter int BUFFER_SIZE  = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  output logic        o_busy,
  output logic        o_finished,
  output logic        o_fx3_oe_n,
  output logic        o_fx3_rd_n,
  input  logic [31:0] i_fx3_data,
  input  logic [1:0]  i_ppfifo_rdy,
  output logic [1:0]  o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  output logic        o_ppfifo_stb,
  output logic [31:0] o_ppfifo_data,
  output logic [15:0] o_words_read
);

  localparam logic [15:0] BUF_WORDS = 16'(BUFFER_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQUIRE,
    S_READ,
    S_DRAIN,
    S_RELEASE,
    S_FINISHED
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               act_q, act_d;
  logic [15:0]              issued_q, issued_d;
  logic [15:0]              side_q, side_d;
  logic [15:0]              words_q, words_d;
  logic [READ_LATENCY-1:0]  vld_q, vld_d;
  logic                     issue;
  logic [23:0]              size_eff;

  // A side size of zero would never terminate a side; treat it as one word.
  always_comb begin
    size_eff = (i_ppfifo_size == 24'd0) ? 24'd1 : i_ppfifo_size;
  end

  // Next-state logic: side acquisition, read issue, drain and release.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    issued_d = issued_q;
    side_d   = side_q;
    words_d  = words_q;
    issue    = 1'b0;

    // Every word leaving the latency pipe is written to the PPFIFO.
    if (vld_q[READ_LATENCY-1]) begin
      words_d = words_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d  = S_ACQUIRE;
          issued_d = 16'd0;
          words_d  = 16'd0;
        end
      end
      S_ACQUIRE: begin
        if (act_q == 2'b00 && i_ppfifo_rdy != 2'b00) begin
          act_d   = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
          side_d  = 16'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        issue    = 1'b1;
        issued_d = issued_q + 16'd1;
        side_d   = side_q + 16'd1;
        if (issued_d == BUF_WORDS || {8'd0, side_d} == size_eff) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Side stays claimed until every issued read has been written.
        if (vld_q == '0) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        act_d   = 2'b00;
        state_d = (issued_q < BUF_WORDS) ? S_ACQUIRE : S_FINISHED;
      end
      S_FINISHED: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        act_d   = 2'b00;
      end
    endcase

    vld_d = (vld_q << 1) | READ_LATENCY'(issue);
  end

  // State, side claim, counters and in-flight tracking; reset aborts all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      act_q    <= 2'b00;
      issued_q <= 16'd0;
      side_q   <= 16'd0;
      words_q  <= 16'd0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      issued_q <= issued_d;
      side_q   <= side_d;
      words_q  <= words_d;
      vld_q    <= vld_d;
    end
  end

  // Output decode from state and pipeline.
  always_comb begin
    o_busy        = (state_q != S_IDLE) && (state_q != S_FINISHED);
    o_finished    = (state_q == S_FINISHED);
    o_fx3_oe_n    = !((state_q == S_ACQUIRE) || (state_q == S_READ) ||
                      (state_q == S_DRAIN)   || (state_q == S_RELEASE));
    o_fx3_rd_n    = !issue;
    o_ppfifo_act  = act_q;
    o_ppfifo_stb  = vld_q[READ_LATENCY-1];
    o_ppfifo_data = i_fx3_data;
    o_words_read  = words_q;
  end

endmodule

// File: tb/tb_fx3_in_path_reader.sv
// Directed bench for fx3_in_path_reader: single side, side split, PPFIFO
// stall, enable handshake, reset abort and alternate read latencies.
module tb_fx3_in_path_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Main DUT: BUFFER_SIZE=256, READ_LATENCY=2.
  logic        en, busy, fin, oe_n, rd_n, stb;
  logic [31:0] fxd, pd;
  logic [1:0]  rdy, act;
  logic [23:0] size;
  logic [15:0] words;

  fx3_in_path_reader #(.BUFFER_SIZE(256), .READ_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .i_enable(en), .o_busy(busy), .o_finished(fin),
    .o_fx3_oe_n(oe_n), .o_fx3_rd_n(rd_n), .i_fx3_data(fxd),
    .i_ppfifo_rdy(rdy), .o_ppfifo_act(act), .i_ppfifo_size(size),
    .o_ppfifo_stb(stb), .o_ppfifo_data(pd), .o_words_read(words)
  );

  // Auxiliary DUTs with latency 4 and 1, eight-word buffers.
  logic        en_a;
  logic [1:0]  rdy_a;
  logic [23:0] size_a;
  logic        busy4, fin4, oe4, rd4, stb4, busy1, fin1, oe1, rd1, stb1;
  logic [31:0] fxd4, pd4, fxd1, pd1;
  logic [1:0]  act4, act1;
  logic [15:0] wr4, wr1;

  fx3_in_path_reader #(.BUFFER_SIZE(8), .READ_LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .i_enable(en_a), .o_busy(busy4), .o_finished(fin4),
    .o_fx3_oe_n(oe4), .o_fx3_rd_n(rd4), .i_fx3_data(fxd4),
    .i_ppfifo_rdy(rdy_a), .o_ppfifo_act(act4), .i_ppfifo_size(size_a),
    .o_ppfifo_stb(stb4), .o_ppfifo_data(pd4), .o_words_read(wr4)
  );

  fx3_in_path_reader #(.BUFFER_SIZE(8), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .i_enable(en_a), .o_busy(busy1), .o_finished(fin1),
    .o_fx3_oe_n(oe1), .o_fx3_rd_n(rd1), .i_fx3_data(fxd1),
    .i_ppfifo_rdy(rdy_a), .o_ppfifo_act(act1), .i_ppfifo_size(size_a),
    .o_ppfifo_stb(stb1), .o_ppfifo_data(pd1), .o_words_read(wr1)
  );

  // FX3 models: each low rd_n cycle returns the next counting word after
  // the configured number of cycles.
  logic [31:0] w2, p2a, p2b;
  always @(posedge clk) begin
    if (rst) begin
      w2 <= 0; p2a <= 0; p2b <= 0;
    end else begin
      p2a <= !rd_n ? w2 : 32'hDEAD_BEEF;
      if (!rd_n) w2 <= w2 + 1;
      p2b <= p2a;
    end
  end
  assign fxd = p2b;

  logic [31:0] w4, p4 [4];
  always @(posedge clk) begin
    if (rst) begin
      w4 <= 0;
      for (int i = 0; i < 4; i++) p4[i] <= 0;
    end else begin
      p4[0] <= !rd4 ? w4 : 32'hDEAD_BEEF;
      if (!rd4) w4 <= w4 + 1;
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
  end
  assign fxd4 = p4[3];

  logic [31:0] w1, p1;
  always @(posedge clk) begin
    if (rst) begin
      w1 <= 0; p1 <= 0;
    end else begin
      p1 <= !rd1 ? w1 : 32'hDEAD_BEEF;
      if (!rd1) w1 <= w1 + 1;
    end
  end
  assign fxd1 = p1;

  // Scoreboard for the main DUT: strobed words must be 0,1,2,... in order,
  // only while a side is claimed; words are also counted per claimed side.
  int         sb_cnt, sb_err, seg_n;
  int         seg_cnt [4];
  logic [1:0] seg_act [4];
  logic [1:0] prev_act;
  always @(negedge clk) begin
    if (rst) begin
      sb_cnt <= 0; sb_err <= 0; seg_n <= 0; prev_act <= 2'b00;
      for (int i = 0; i < 4; i++) begin
        seg_cnt[i] <= 0; seg_act[i] <= 2'b00;
      end
    end else begin
      prev_act <= act;
      if (prev_act == 2'b00 && act != 2'b00) begin
        if (seg_n < 4) seg_act[seg_n] <= act;
        seg_n <= seg_n + 1;
      end
      if (stb) begin
        if (pd != 32'(sb_cnt) || act == 2'b00) sb_err <= sb_err + 1;
        sb_cnt <= sb_cnt + 1;
        if (seg_n > 0 && seg_n <= 4) seg_cnt[seg_n-1] <= seg_cnt[seg_n-1] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input int maxc);
    for (int i = 0; i < maxc && fin !== 1'b1; i++) @(negedge clk);
    check(tag, 32'(fin), 32'd1);
  endtask

  task automatic wait_act(input string tag, input logic [1:0] exp, input int maxc);
    for (int i = 0; i < maxc && act !== exp; i++) @(negedge clk);
    check(tag, 32'(act), 32'(exp));
  endtask

  task automatic wait_words(input string tag, input int n, input int maxc);
    for (int i = 0; i < maxc && words !== 16'(n); i++) @(negedge clk);
    check(tag, 32'(words), 32'(n));
  endtask

  initial begin
    int fr4, fs4, n4, e4, fr1, fs1, n1, e1;
    rst = 1'b1; en = 1'b0; rdy = 2'b00; size = 24'd512;
    en_a = 1'b0; rdy_a = 2'b01; size_a = 24'd512;

    // Reset state and single-side transfer.
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_fin", 32'(fin), 0);
    check("rst_oe_n", 32'(oe_n), 1);
    check("rst_rd_n", 32'(rd_n), 1);
    check("rst_act", 32'(act), 0);
    check("rst_stb", 32'(stb), 0);
    check("rst_words", 32'(words), 0);

    rdy = 2'b01;
    @(negedge clk) en = 1'b1;
    @(posedge clk);            // edge N: enable sampled
    #1 check("busy_n1", 32'(busy), 1);
    @(posedge clk);            // N+1: side claimed, first read
    #1 check("act_n1", 32'(act), 32'b01);
    check("rd_first", 32'(rd_n), 0);
    check("oe_read", 32'(oe_n), 0);
    @(posedge clk);            // N+2
    #1 check("stb_early", 32'(stb), 0);
    @(posedge clk);            // N+3: latency 2 after first read
    #1 check("stb_first", 32'(stb), 1);
    check("data_first", pd, 0);
    repeat (257) @(posedge clk);  // N+260
    #1 check("fin_early", 32'(fin), 0);
    @(posedge clk);               // N+261
    #1 check("fin_on", 32'(fin), 1);
    check("single_words", 32'(words), 256);
    check("fin_busy", 32'(busy), 0);
    check("fin_oe_n", 32'(oe_n), 1);
    check("single_sb_cnt", 32'(sb_cnt), 256);
    check("single_sb_err", 32'(sb_err), 0);
    check("single_segs", 32'(seg_n), 1);
    check("single_seg0", 32'(seg_cnt[0]), 256);

    // Handshake: finished holds while enable stays high.
    repeat (10) @(negedge clk);
    check("fin_hold", 32'(fin), 1);
    en = 1'b0;
    @(posedge clk);
    #1 check("fin_drop", 32'(fin), 0);
    check("idle_busy", 32'(busy), 0);
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 check("rearm_busy", 32'(busy), 1);
    check("rearm_words", 32'(words), 0);

    // Reset in the middle of the second buffer.
    wait_words("mid_words", 37, 200);
    check("mid_sb_err", 32'(sb_err), 0);
    rst = 1'b1; en = 1'b0;
    @(posedge clk);
    #1 check("abort_act", 32'(act), 0);
    check("abort_rd_n", 32'(rd_n), 1);
    check("abort_oe_n", 32'(oe_n), 1);
    check("abort_stb", 32'(stb), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_fin", 32'(fin), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Split across sides of 100 words.
    do_reset();
    size = 24'd100; rdy = 2'b11;
    @(negedge clk) en = 1'b1;
    wait_act("split_a0", 2'b01, 20);
    rdy = 2'b10;
    wait_act("split_a1", 2'b10, 200);
    rdy = 2'b01;
    wait_fin("split_fin", 600);
    check("split_segs", 32'(seg_n), 3);
    check("split_seg0", 32'(seg_cnt[0]), 100);
    check("split_seg1", 32'(seg_cnt[1]), 100);
    check("split_seg2", 32'(seg_cnt[2]), 56);
    check("split_act0", 32'(seg_act[0]), 32'b01);
    check("split_act1", 32'(seg_act[1]), 32'b10);
    check("split_act2", 32'(seg_act[2]), 32'b01);
    check("split_sb_cnt", 32'(sb_cnt), 256);
    check("split_sb_err", 32'(sb_err), 0);
    check("split_words", 32'(words), 256);

    // PPFIFO stall: no side ready for 20 cycles.
    do_reset();
    size = 24'd512; rdy = 2'b00;
    @(negedge clk) en = 1'b1;
    repeat (20) @(negedge clk);
    check("stall_rd_n", 32'(rd_n), 1);
    check("stall_oe_n", 32'(oe_n), 0);
    check("stall_busy", 32'(busy), 1);
    check("stall_act", 32'(act), 0);
    rdy = 2'b10;
    wait_act("stall_act1", 2'b10, 5);
    wait_fin("stall_fin", 400);
    check("stall_words", 32'(words), 256);
    check("stall_seg_act", 32'(seg_act[0]), 32'b10);
    check("stall_sb_cnt", 32'(sb_cnt), 256);
    check("stall_sb_err", 32'(sb_err), 0);

    // Latency 4 and latency 1 builds.
    do_reset();
    fr4 = -1; fs4 = -1; n4 = 0; e4 = 0;
    fr1 = -1; fs1 = -1; n1 = 0; e1 = 0;
    @(negedge clk) en_a = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk);
      #1;
      if (!rd4 && fr4 < 0) fr4 = t;
      if (stb4 && fs4 < 0) fs4 = t;
      if (stb4) begin
        if (pd4 != 32'(n4)) e4++;
        n4++;
      end
      if (!rd1 && fr1 < 0) fr1 = t;
      if (stb1 && fs1 < 0) fs1 = t;
      if (stb1) begin
        if (pd1 != 32'(n1)) e1++;
        n1++;
      end
    end
    check("l4_latency", 32'(fs4 - fr4), 4);
    check("l1_latency", 32'(fs1 - fr1), 1);
    check("l4_strobes", 32'(n4), 8);
    check("l1_strobes", 32'(n1), 8);
    check("l4_words", 32'(wr4), 8);
    check("l1_words", 32'(wr1), 8);
    check("l4_data_err", 32'(e4), 0);
    check("l1_data_err", 32'(e1), 0);
    check("l4_fin", 32'(fin4), 1);
    check("l1_fin", 32'(fin1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
